// File: rtl/rc4_decrypt_engine.sv
// rc4_decrypt_engine: RC4 key schedule and keystream over external S-RAM,
// decrypting a ROM into a RAM and stopping early on non-plaintext bytes.
module rc4_decrypt_engine #(
  parameter int KEY_BYTES = 3,
  parameter int MSG_LEN   = 32,
  parameter int CHECK_EN  = 1
) (
  input  logic                   CLK_10Hz,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic                   busy,
  output logic                   done,
  output logic                   valid,
  output logic [7:0]             s_addr,
  output logic [7:0]             s_wdata,
  output logic                   s_wren,
  input  logic [7:0]             s_q,
  output logic [7:0]             e_addr,
  input  logic [7:0]             e_q,
  output logic [7:0]             d_addr,
  output logic [7:0]             d_wdata,
  output logic                   d_wren
);

  localparam logic [4:0] IDLE     = 5'd0;
  localparam logic [4:0] INIT     = 5'd1;
  localparam logic [4:0] KSA_RI   = 5'd2;
  localparam logic [4:0] KSA_RI_W = 5'd3;
  localparam logic [4:0] KSA_RJ   = 5'd4;
  localparam logic [4:0] KSA_RJ_W = 5'd5;
  localparam logic [4:0] KSA_WJ   = 5'd6;
  localparam logic [4:0] KSA_WI   = 5'd7;
  localparam logic [4:0] PR_RI    = 5'd8;
  localparam logic [4:0] PR_RI_W  = 5'd9;
  localparam logic [4:0] PR_RJ    = 5'd10;
  localparam logic [4:0] PR_RJ_W  = 5'd11;
  localparam logic [4:0] PR_WJ    = 5'd12;
  localparam logic [4:0] PR_WI    = 5'd13;
  localparam logic [4:0] PR_RF    = 5'd14;
  localparam logic [4:0] PR_RF_W  = 5'd15;
  localparam logic [4:0] PR_XOR   = 5'd16;
  localparam logic [4:0] PR_WD    = 5'd17;
  localparam logic [4:0] PR_FIN   = 5'd18;
  localparam logic [4:0] DONE     = 5'd19;

  localparam int         KW     = 8 * KEY_BYTES;
  localparam logic [7:0] K_LAST = 8'(MSG_LEN - 1);

  logic [4:0]    state;
  logic [7:0]    i, j, k, f, si, sj;
  logic [KW-1:0] key_r;
  logic [7:0]    kbyte, j_ksa, j_pr, i_nx, d_nx;
  logic          plain;

  // key_r rotates one byte per KSA step, so its top byte is key[i mod KEY_BYTES]
  assign kbyte = key_r[KW-1 -: 8];
  assign j_ksa = j + s_q + kbyte;
  assign j_pr  = j + s_q;
  assign i_nx  = i + 8'd1;
  assign d_nx  = e_q ^ f;
  assign plain = (d_nx >= 8'h61 && d_nx <= 8'h7A)
              || (d_nx == 8'h20);

  // Main sequencer: every memory read gets one wait state before q is used
  always_ff @(posedge CLK_10Hz or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      valid   <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
      s_wren  <= 1'b0;
      e_addr  <= '0;
      d_addr  <= '0;
      d_wdata <= '0;
      d_wren  <= 1'b0;
      i       <= '0;
      j       <= '0;
      k       <= '0;
      f       <= '0;
      si      <= '0;
      sj      <= '0;
      key_r   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= INIT;
            busy    <= 1'b1;
            valid   <= 1'b0;
            key_r   <= key;
            s_addr  <= 8'd0;
            s_wdata <= 8'd0;
            s_wren  <= 1'b1;
            i       <= 8'd1;
            j       <= 8'd0;
            k       <= 8'd0;
            f       <= 8'd0;
          end
        end
        INIT: begin
          if (i == 8'd0) begin
            s_wren <= 1'b0;
            state  <= KSA_RI;
          end else begin
            s_addr  <= i;
            s_wdata <= i;
            i       <= i_nx;
          end
        end
        KSA_RI: begin
          s_addr <= i;
          s_wren <= 1'b0;
          state  <= KSA_RI_W;
        end
        KSA_RI_W: state <= KSA_RJ;
        KSA_RJ: begin
          si     <= s_q;
          j      <= j_ksa;
          s_addr <= j_ksa;
          state  <= KSA_RJ_W;
        end
        KSA_RJ_W: state <= KSA_WJ;
        KSA_WJ: begin
          sj      <= s_q;
          s_addr  <= j;
          s_wdata <= si;
          s_wren  <= 1'b1;
          state   <= KSA_WI;
        end
        KSA_WI: begin
          s_addr  <= i;
          s_wdata <= sj;
          s_wren  <= 1'b1;
          key_r   <= (key_r << 8) | (key_r >> (KW - 8));
          i       <= i_nx;
          if (i == 8'hFF) begin
            j     <= 8'd0;
            state <= PR_RI;
          end else begin
            state <= KSA_RI;
          end
        end
        PR_RI: begin
          i      <= i_nx;
          s_addr <= i_nx;
          s_wren <= 1'b0;
          d_wren <= 1'b0;
          state  <= PR_RI_W;
        end
        PR_RI_W: state <= PR_RJ;
        PR_RJ: begin
          si     <= s_q;
          j      <= j_pr;
          s_addr <= j_pr;
          state  <= PR_RJ_W;
        end
        PR_RJ_W: state <= PR_WJ;
        PR_WJ: begin
          sj      <= s_q;
          s_addr  <= j;
          s_wdata <= si;
          s_wren  <= 1'b1;
          state   <= PR_WI;
        end
        PR_WI: begin
          s_addr  <= i;
          s_wdata <= sj;
          state   <= PR_RF;
        end
        PR_RF: begin
          s_addr <= si + sj;
          s_wren <= 1'b0;
          e_addr <= k;
          state  <= PR_RF_W;
        end
        PR_RF_W: state <= PR_XOR;
        PR_XOR: begin
          f      <= s_q;
          d_addr <= k;
          state  <= PR_WD;
        end
        PR_WD: begin
          if ((CHECK_EN != 0) && !plain) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            valid <= 1'b0;
            state <= DONE;
          end else begin
            d_wdata <= d_nx;
            d_wren  <= 1'b1;
            k       <= k + 8'd1;
            state   <= (k == K_LAST) ? PR_FIN : PR_RI;
          end
        end
        PR_FIN: begin
          d_wren <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b1;
          valid  <= 1'b1;
          state  <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_decrypt_engine.sv
// tb_rc4_decrypt_engine: two engines against modelled memories,
// checked against a plain software RC4 model.
module tb_rc4_decrypt_engine;

  logic CLK_10Hz = 1'b0;
  always #5 CLK_10Hz = ~CLK_10Hz;

  logic reset;

  logic        start_a, busy_a, done_a, valid_a;
  logic [23:0] key_a;
  logic [7:0]  s_addr_a, s_wdata_a, s_q_a, e_addr_a, e_q_a;
  logic [7:0]  d_addr_a, d_wdata_a;
  logic        s_wren_a, d_wren_a;

  logic        start_b, busy_b, done_b, valid_b;
  logic [7:0]  key_b;
  logic [7:0]  s_addr_b, s_wdata_b, s_q_b, e_addr_b, e_q_b;
  logic [7:0]  d_addr_b, d_wdata_b;
  logic        s_wren_b, d_wren_b;

  rc4_decrypt_engine dut_a (
    .CLK_10Hz(CLK_10Hz), .reset(reset), .start(start_a),
    .key(key_a), .busy(busy_a), .done(done_a), .valid(valid_a),
    .s_addr(s_addr_a), .s_wdata(s_wdata_a), .s_wren(s_wren_a),
    .s_q(s_q_a), .e_addr(e_addr_a), .e_q(e_q_a),
    .d_addr(d_addr_a), .d_wdata(d_wdata_a), .d_wren(d_wren_a)
  );

  rc4_decrypt_engine #(
    .KEY_BYTES(1), .MSG_LEN(256), .CHECK_EN(0)
  ) dut_b (
    .CLK_10Hz(CLK_10Hz), .reset(reset), .start(start_b),
    .key(key_b), .busy(busy_b), .done(done_b), .valid(valid_b),
    .s_addr(s_addr_b), .s_wdata(s_wdata_b), .s_wren(s_wren_b),
    .s_q(s_q_b), .e_addr(e_addr_b), .e_q(e_q_b),
    .d_addr(d_addr_b), .d_wdata(d_wdata_b), .d_wren(d_wren_b)
  );

  logic [7:0]  sram_a [256];
  logic [7:0]  rom_a  [256];
  logic [7:0]  sram_b [256];
  logic [7:0]  rom_b  [256];
  logic [7:0]  s_ar_a, e_ar_a, s_ar_b, e_ar_b;
  logic [15:0] wq_a [$];
  logic [15:0] wq_b [$];

  // Synchronous memories: address registered, q read from the register
  always @(posedge CLK_10Hz) begin
    if (s_wren_a) sram_a[s_addr_a] <= s_wdata_a;
    if (s_wren_b) sram_b[s_addr_b] <= s_wdata_b;
    if (d_wren_a) wq_a.push_back({d_addr_a, d_wdata_a});
    if (d_wren_b) wq_b.push_back({d_addr_b, d_wdata_b});
    s_ar_a <= s_addr_a;
    e_ar_a <= e_addr_a;
    s_ar_b <= s_addr_b;
    e_ar_b <= e_addr_b;
  end
  assign s_q_a = sram_a[s_ar_a];
  assign e_q_a = rom_a[e_ar_a];
  assign s_q_b = sram_b[s_ar_b];
  assign e_q_b = rom_b[e_ar_b];

  int checks = 0;
  int errors = 0;

  logic [255:0] phrase = "the quick brown fox jumps over t";
  logic [7:0]   ptm [256];

  logic [7:0] m_S [256];
  logic [7:0] m_d [256];
  int         m_n;
  bit         m_valid;

  function automatic bit is_plain(input logic [7:0] b);
    return (b >= 8'h61 && b <= 8'h7A) || (b == 8'h20);
  endfunction

  // Textbook RC4 over arrays; fills m_S, m_d, m_n, m_valid
  task automatic model(input logic [127:0] kv, input int kl,
                       input int ml, input bit chk,
                       input logic [7:0] c [256]);
    logic [7:0] S [256];
    logic [7:0] t, kb, fz, d;
    int ii, jj;
    for (int x = 0; x < 256; x++) S[x] = 8'(x);
    jj = 0;
    for (int x = 0; x < 256; x++) begin
      kb = 8'(kv >> (8 * (kl - 1 - (x % kl))));
      jj = (jj + int'(S[x]) + int'(kb)) % 256;
      t = S[x]; S[x] = S[jj]; S[jj] = t;
    end
    ii = 0; jj = 0; m_n = 0; m_valid = 1'b1;
    for (int x = 0; x < ml; x++) begin
      ii = (ii + 1) % 256;
      jj = (jj + int'(S[ii])) % 256;
      t = S[ii]; S[ii] = S[jj]; S[jj] = t;
      fz = S[(int'(S[ii]) + int'(S[jj])) % 256];
      d = c[x] ^ fz;
      if (chk && !is_plain(d)) begin
        m_valid = 1'b0;
        break;
      end
      m_d[x] = d;
      m_n++;
    end
    for (int x = 0; x < 256; x++) m_S[x] = S[x];
  endtask

  // Encrypt ptm under key k into rom_a
  task automatic make_rom_a(input logic [23:0] k);
    logic [7:0] z [256];
    for (int x = 0; x < 256; x++) z[x] = 8'h00;
    model({104'd0, k}, 3, 256, 1'b0, z);
    for (int x = 0; x < 256; x++) rom_a[x] = ptm[x] ^ m_d[x];
  endtask

  task automatic load_phrase();
    logic [255:0] p;
    p = phrase;
    for (int x = 0; x < 256; x++)
      ptm[x] = (x < 32) ? p[8*(31-x) +: 8] : 8'h20;
  endtask

  function automatic int diff_w(input logic [15:0] q [$]);
    int b = 0;
    if (q.size() != m_n) b++;
    for (int x = 0; x < q.size() && x < m_n; x++)
      if (q[x] !== {8'(x), m_d[x]}) b++;
    return b;
  endfunction

  function automatic int diff_s(input logic [7:0] a [256]);
    int b = 0;
    for (int x = 0; x < 256; x++)
      if (a[x] !== m_S[x]) b++;
    return b;
  endfunction

  task automatic wait_a(input int lim, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < lim; c++) begin
      @(negedge CLK_10Hz);
      if (done_a) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_a(input logic [23:0] k, output bit seen);
    key_a = k;
    wq_a.delete();
    start_a = 1'b1;
    @(negedge CLK_10Hz);
    start_a = 1'b0;
    wait_a(6000, seen);
  endtask

  task automatic test_reset();
    logic [44:0] oa, ob;
    reset = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    key_a = '0; key_b = '0;
    #12;
    oa = {busy_a, done_a, valid_a, s_wren_a, d_wren_a, s_addr_a,
          s_wdata_a, e_addr_a, d_addr_a, d_wdata_a};
    ob = {busy_b, done_b, valid_b, s_wren_b, d_wren_b, s_addr_b,
          s_wdata_b, e_addr_b, d_addr_b, d_wdata_b};
    checks++;
    if (oa !== '0) begin
      errors++;
      $display("FAIL reset_a: outputs %h, want 0", oa);
    end
    checks++;
    if (ob !== '0) begin
      errors++;
      $display("FAIL reset_b: outputs %h, want 0", ob);
    end
    @(negedge CLK_10Hz);
    reset = 1'b0;
    repeat (3) @(negedge CLK_10Hz);
    checks++;
    if (busy_a !== 1'b0 || s_wren_a !== 1'b0) begin
      errors++;
      $display("FAIL idle_a: busy %b s_wren %b, want 0 0",
               busy_a, s_wren_a);
    end
  endtask

  task automatic test_init();
    bit seen;
    int bad = 0;
    load_phrase();
    make_rom_a(24'h000249);
    key_a = 24'h000249;
    wq_a.delete();
    start_a = 1'b1;
    @(negedge CLK_10Hz);
    start_a = 1'b0;
    for (int x = 0; x < 256; x++) begin
      if (!(s_wren_a === 1'b1 && s_addr_a === 8'(x) &&
            s_wdata_a === 8'(x) && busy_a === 1'b1)) bad++;
      @(negedge CLK_10Hz);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL init_seq: %0d bad cycles, want 0", bad);
    end
    checks++;
    if (s_wren_a !== 1'b0 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL init_end: s_wren %b busy %b, want 0 1",
               s_wren_a, busy_a);
    end
    wait_a(6000, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL init_run_done: no done pulse, want one");
    end
  endtask

  task automatic test_valid();
    bit seen;
    int bad = 0;
    load_phrase();
    make_rom_a(24'h000249);
    model(128'h000249, 3, 32, 1'b1, rom_a);
    run_a(24'h000249, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL valid_done: timeout, want done pulse");
    end
    checks++;
    if (valid_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL valid_flags: valid %b busy %b, want 1 0",
               valid_a, busy_a);
    end
    for (int x = 0; x < wq_a.size(); x++)
      if (wq_a[x] !== {8'(x), ptm[x]}) bad++;
    checks++;
    if (wq_a.size() != 32 || bad != 0) begin
      errors++;
      $display("FAIL valid_text: %0d writes %0d bad, want 32 0",
               wq_a.size(), bad);
    end
    checks++;
    if (diff_s(sram_a) != 0) begin
      errors++;
      $display("FAIL valid_sram: %0d diffs, want 0", diff_s(sram_a));
    end
    @(negedge CLK_10Hz);
    checks++;
    if (done_a !== 1'b0 || s_wren_a !== 1'b0 ||
        d_wren_a !== 1'b0 || valid_a !== 1'b1) begin
      errors++;
      $display("FAIL valid_hold: done %b sw %b dw %b valid %b, want 0 0 0 1",
               done_a, s_wren_a, d_wren_a, valid_a);
    end
  endtask

  task automatic test_abort();
    bit seen;
    load_phrase();
    make_rom_a(24'h000249);
    model(128'h000248, 3, 32, 1'b1, rom_a);
    run_a(24'h000248, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL abort_done: timeout, want done pulse");
    end
    checks++;
    if (valid_a !== m_valid) begin
      errors++;
      $display("FAIL abort_valid: %b, want %b", valid_a, m_valid);
    end
    checks++;
    if (diff_w(wq_a) != 0) begin
      errors++;
      $display("FAIL abort_writes: %0d writes, want %0d",
               wq_a.size(), m_n);
    end
    checks++;
    if (diff_s(sram_a) != 0) begin
      errors++;
      $display("FAIL abort_sram: %0d diffs, want 0", diff_s(sram_a));
    end
    checks++;
    if (s_wren_a !== 1'b0 || d_wren_a !== 1'b0) begin
      errors++;
      $display("FAIL abort_wren: sw %b dw %b, want 0 0",
               s_wren_a, d_wren_a);
    end
  endtask

  task automatic test_key1();
    bit seen = 1'b0;
    for (int x = 0; x < 256; x++) rom_b[x] = 8'($urandom);
    model(128'h0, 1, 256, 1'b0, rom_b);
    key_b = 8'h00;
    wq_b.delete();
    start_b = 1'b1;
    @(negedge CLK_10Hz);
    start_b = 1'b0;
    for (int c = 0; c < 8000; c++) begin
      @(negedge CLK_10Hz);
      if (done_b) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen || valid_b !== 1'b1) begin
      errors++;
      $display("FAIL key1_done: seen %b valid %b, want 1 1",
               seen, valid_b);
    end
    checks++;
    if (diff_w(wq_b) != 0) begin
      errors++;
      $display("FAIL key1_stream: %0d writes %0d diffs, want 256 0",
               wq_b.size(), diff_w(wq_b));
    end
    checks++;
    if (diff_s(sram_b) != 0) begin
      errors++;
      $display("FAIL key1_sram: %0d diffs, want 0", diff_s(sram_b));
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    load_phrase();
    make_rom_a(24'h000249);
    model(128'h000249, 3, 32, 1'b1, rom_a);
    key_a = 24'h000249;
    wq_a.delete();
    start_a = 1'b1;
    @(negedge CLK_10Hz);
    start_a = 1'b0;
    for (int c = 0; c < 6000 && wq_a.size() < 10; c++)
      @(negedge CLK_10Hz);
    start_a = 1'b1;
    wait_a(6000, seen);
    checks++;
    if (!seen || valid_a !== 1'b1 || diff_w(wq_a) != 0) begin
      errors++;
      $display("FAIL b2b_first: seen %b valid %b diffs %0d, want 1 1 0",
               seen, valid_a, diff_w(wq_a));
    end
    @(negedge CLK_10Hz);
    checks++;
    if (busy_a !== 1'b1 || s_wren_a !== 1'b1 || s_addr_a !== 8'h00) begin
      errors++;
      $display("FAIL b2b_restart: busy %b sw %b addr %h, want 1 1 00",
               busy_a, s_wren_a, s_addr_a);
    end
    start_a = 1'b0;
    wq_a.delete();
    wait_a(6000, seen);
    checks++;
    if (!seen || valid_a !== 1'b1 || diff_w(wq_a) != 0) begin
      errors++;
      $display("FAIL b2b_second: seen %b valid %b diffs %0d, want 1 1 0",
               seen, valid_a, diff_w(wq_a));
    end
  endtask

  task automatic test_random();
    bit seen;
    logic [23:0] k;
    int p, r, exp_n;
    for (int it = 0; it < 4; it++) begin
      k = 24'($urandom);
      for (int x = 0; x < 256; x++) begin
        r = $urandom_range(0, 26);
        ptm[x] = (r == 26) ? 8'h20 : 8'(8'h61 + r);
      end
      make_rom_a(k);
      exp_n = 32;
      if (it % 2 == 1) begin
        p = $urandom_range(0, 31);
        rom_a[p] = rom_a[p] ^ ptm[p] ^ (8'h80 | 8'($urandom));
        exp_n = p;
      end
      model({104'd0, k}, 3, 32, 1'b1, rom_a);
      run_a(k, seen);
      checks++;
      if (!seen || valid_a !== (exp_n == 32)) begin
        errors++;
        $display("FAIL rand_flags[%0d]: seen %b valid %b, want 1 %b",
                 it, seen, valid_a, exp_n == 32);
      end
      checks++;
      if (wq_a.size() != exp_n || diff_w(wq_a) != 0) begin
        errors++;
        $display("FAIL rand_writes[%0d]: %0d writes %0d diffs, want %0d 0",
                 it, wq_a.size(), diff_w(wq_a), exp_n);
      end
      checks++;
      if (diff_s(sram_a) != 0) begin
        errors++;
        $display("FAIL rand_sram[%0d]: %0d diffs, want 0",
                 it, diff_s(sram_a));
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    logic [44:0] oa;
    load_phrase();
    make_rom_a(24'h000249);
    model(128'h000249, 3, 32, 1'b1, rom_a);
    key_a = 24'h000249;
    wq_a.delete();
    start_a = 1'b1;
    @(negedge CLK_10Hz);
    start_a = 1'b0;
    repeat (256 + 100 * 6 + 2) @(negedge CLK_10Hz);
    checks++;
    if (busy_a !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy: %b, want 1", busy_a);
    end
    #2 reset = 1'b1;
    #1;
    oa = {busy_a, done_a, valid_a, s_wren_a, d_wren_a, s_addr_a,
          s_wdata_a, e_addr_a, d_addr_a, d_wdata_a};
    checks++;
    if (oa !== '0) begin
      errors++;
      $display("FAIL mid_reset: outputs %h, want 0", oa);
    end
    @(negedge CLK_10Hz);
    reset = 1'b0;
    repeat (2) @(negedge CLK_10Hz);
    checks++;
    if (wq_a.size() != 0 || busy_a !== 1'b0 || s_wren_a !== 1'b0) begin
      errors++;
      $display("FAIL mid_quiet: writes %0d busy %b sw %b, want 0 0 0",
               wq_a.size(), busy_a, s_wren_a);
    end
    run_a(24'h000249, seen);
    checks++;
    if (!seen || valid_a !== 1'b1 || diff_w(wq_a) != 0 ||
        diff_s(sram_a) != 0) begin
      errors++;
      $display("FAIL mid_rerun: seen %b valid %b wdiff %0d sdiff %0d, want 1 1 0 0",
               seen, valid_a, diff_w(wq_a), diff_s(sram_a));
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_valid();
    test_abort();
    test_key1();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
